fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. It owns the fetch PC, issues in-order requests to instruction memory over a valid/ready handshake, and tolerates variable response latency. Returned instructions go into a prefetch queue, and the queue presents them to decode. Branch and jump redirects from decode flush the queue and discard in-flight responses, which replaces the single-register PC with fixed `PC+4` of the earlier fetch stage.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_if.sv | 7 +
 rtl/fetch_queue.sv | 32 +++
 rtl/fetch_unit.sv | 60 ++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch stage.
package fetch_pkg;
    localparam logic [31:0] NOP = 32'h0;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    function automatic logic [63:0] jump_target(input logic [63:0] pcplus4, input logic [27:0] pcj);
        return {pcplus4[63:28], pcj};
    endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response handshake.
interface fetch_if #(parameter int XLEN = 32) ();
    logic req_valid, req_ready, rsp_valid;
    logic [XLEN-1:0] req_addr, rsp_data;
    modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO with wrap-bit pointers and a flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter type T = fetch_entry_t
) (
    input  logic CLK,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  T din,
    output T dout,
    output logic [$clog2(QDEPTH):0] count,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(QDEPTH);
    T mem [QDEPTH];
    logic [AW:0] wp, rp;
    always_ff @(posedge CLK) begin
        wp <= (reset || flush) ? '0 : wp + (AW+1)'(push);
        rp <= (reset || flush) ? '0 : rp + (AW+1)'(pop);
    end
    always_ff @(posedge CLK)
        if (push) mem[wp[AW-1:0]] <= din;
    assign count = wp - rp;
    assign empty = count == '0;
    assign full = count == (AW+1)'(QDEPTH);
    assign dout = mem[rp[AW-1:0]];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, credit-limited imem requests, prefetch queue and
// redirect handling that discards responses for abandoned requests.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int QDEPTH = 4
) (
    input  logic CLK,
    input  logic reset,
    fetch_if.master imem,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic ValidD,
    input  logic StallD,
    input  logic BranchD,
    input  logic [XLEN-1:0] PCBranchD,
    input  logic JumpD,
    input  logic [27:0] PCJD
);
    localparam int W = $clog2(QDEPTH) + 1;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;
    logic [XLEN-1:0] pc_f, pc_q, target;
    logic [W-1:0] inflight, drop, inflight_next, count;
    logic redirect, accept, drop_now, push, pop, empty, full;
    entry_t din, head;
    assign redirect = ValidD & (JumpD | BranchD);
    assign target = JumpD ? XLEN'(jump_target(64'(PCPlus4D), PCJD)) : PCBranchD;
    // queued plus outstanding never exceeds QDEPTH, so pushes always fit
    assign imem.req_valid = !reset & !redirect & (int'(inflight) + int'(count) < QDEPTH);
    assign imem.req_addr = pc_f;
    assign accept = imem.req_valid & imem.req_ready;
    assign drop_now = imem.rsp_valid & (drop != '0);
    assign push = imem.rsp_valid & !drop_now & !redirect;
    assign pop = ValidD & !StallD & !redirect;
    assign inflight_next = inflight + W'(accept) - W'(imem.rsp_valid);
    assign din = '{pc: pc_q, instr: imem.rsp_data};
    // drop is always zero when a redirect fires (queue stays empty while
    // draining), so every request still outstanding becomes stale
    always_ff @(posedge CLK) begin
        inflight <= reset ? '0 : inflight_next;
        drop <= reset ? '0 : redirect ? inflight_next : drop - W'(drop_now);
        pc_f <= reset ? RESET_PC : redirect ? target : accept ? pc_f + XLEN'(4) : pc_f;
        pc_q <= reset ? RESET_PC : redirect ? target : push ? pc_q + XLEN'(4) : pc_q;
    end
    fetch_queue #(.QDEPTH(QDEPTH), .T(entry_t)) q (
        .CLK(CLK), .reset(reset), .push(push), .pop(pop), .flush(redirect),
        .din(din), .dout(head), .count(count), .empty(empty), .full(full)
    );
    assert property (@(posedge CLK) disable iff (reset) !(push && full && !pop));
    assign ValidD = !empty;
    assign PCD = head.pc;
    assign InstrD = head.instr;
    assign PCPlus4D = PCD + XLEN'(4);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against an
// in-order program-counter model and a queued-latency memory model.
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int QD = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    typedef struct {
        int due;
        logic [31:0] addr;
    } req_t;
    logic CLK = 0, reset = 1;
    logic [31:0] InstrD, PCD, PCPlus4D, PCBranchD = '0;
    logic ValidD, StallD = 0, BranchD = 0, JumpD = 0;
    logic [27:0] PCJD = '0;
    fetch_if #(.XLEN(32)) imem ();
    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .CLK(CLK), .reset(reset), .imem(imem), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .StallD(StallD), .BranchD(BranchD),
        .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJD(PCJD)
    );
    always #5 CLK = ~CLK;
    int checks = 0, errors = 0, cyc = 0, lat = 1;
    int unsigned ready_pct = 100, rsp_pct = 100;
    bit rnd_lat = 0;
    req_t pend[$];
    logic [31:0] exp_pc = RST_PC, exp_req = RST_PC, last_pcd, last_addr;
    logic last_valid, last_reqv;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, want);
        end
    endtask

    // one clock cycle: drive at posedge+1, check at negedge, update model
    task automatic tick(input bit br, input logic [31:0] bt, input bit jp, input logic [27:0] pj);
        logic [31:0] p4, tgt;
        bit redir;
        imem.req_ready = $urandom_range(99) < ready_pct;
        imem.rsp_valid = !reset && pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rsp_pct;
        if (imem.rsp_valid) imem.rsp_data = word(pend[0].addr);
        else imem.rsp_data = NOP;
        BranchD = br; PCBranchD = bt; JumpD = jp; PCJD = pj;
        @(negedge CLK);
        redir = ValidD && (br || jp);
        last_valid = ValidD; last_pcd = PCD; last_reqv = imem.req_valid; last_addr = imem.req_addr;
        if (reset) chk("req_in_reset", 32'(imem.req_valid), 32'd0);
        else begin
            if (ValidD) begin
                chk("PCD", PCD, exp_pc);
                chk("InstrD", InstrD, word(exp_pc));
                chk("PCPlus4D", PCPlus4D, exp_pc + 32'd4);
            end
            if (redir) chk("req_in_redirect", 32'(imem.req_valid), 32'd0);
            if (imem.req_valid) begin
                chk("req_addr", imem.req_addr, exp_req);
                chk("credit", 32'(((exp_req - exp_pc) >> 2) < 32'(QD)), 32'd1);
            end
        end
        if (imem.rsp_valid) void'(pend.pop_front());
        if (imem.req_valid && imem.req_ready) begin
            pend.push_back('{due: cyc + (rnd_lat ? int'($urandom_range(1, 4)) : lat), addr: imem.req_addr});
            exp_req += 32'd4;
        end
        if (redir) begin
            p4 = exp_pc + 32'd4;
            tgt = jp ? {p4[31:28], pj} : bt;
            exp_pc = tgt;
            exp_req = tgt;
        end else if (ValidD && !StallD) exp_pc += 32'd4;
        if (reset) begin
            pend.delete();
            exp_pc = RST_PC;
            exp_req = RST_PC;
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) tick(0, '0, 0, '0);
        reset = 0;
    endtask

    task automatic wait_pc(input logic [31:0] pc, input string tag);
        for (int i = 0; i < 60 && !(ValidD && PCD === pc); i++) tick(0, '0, 0, '0);
        chk(tag, ValidD ? PCD : 32'hFFFF_FFFF, pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r2;
        bit br, jp;
        @(posedge CLK);
        #1;
        do_reset();
        tick(0, '0, 0, '0);
        chk("first_reqv", 32'(last_reqv), 32'd1);
        chk("first_addr", last_addr, RST_PC);
        chk("valid_c0", 32'(last_valid), 32'd0);
        tick(0, '0, 0, '0);
        chk("valid_c1", 32'(last_valid), 32'd0);
        tick(0, '0, 0, '0);
        chk("valid_c2", 32'(last_valid), 32'd1);
        chk("pcd_c2", last_pcd, RST_PC);
        for (int i = 0; i < 10; i++) begin
            tick(0, '0, 0, '0);
            chk("throughput", 32'(last_valid), 32'd1);
        end
        StallD = 1;
        repeat (10) tick(0, '0, 0, '0);
        chk("stall_reqv", 32'(last_reqv), 32'd0);
        chk("stall_ahead", (exp_req - exp_pc) >> 2, 32'(QD));
        StallD = 0;
        repeat (8) tick(0, '0, 0, '0);
        lat = 3;
        do_reset();
        wait_pc(32'h10, "reach_10");
        tick(1, 32'h100, 0, '0);
        for (int i = 0; i < 4; i++) begin
            tick(0, '0, 0, '0);
            chk("br_gap", 32'(last_valid), 32'd0);
        end
        tick(0, '0, 0, '0);
        chk("br_valid", 32'(last_valid), 32'd1);
        chk("br_pcd", last_pcd, 32'h100);
        lat = 1;
        wait_pc(32'h104, "seq_104");
        tick(1, 32'h1000_0000, 0, '0);
        wait_pc(32'h1000_0008, "reach_jmp");
        tick(0, '0, 1, 28'h40);
        wait_pc(32'h1000_0040, "jump_tgt");
        tick(1, 32'hDEAD_BEE0, 1, 28'h200);
        wait_pc(32'h1000_0200, "jump_prio");
        rnd_lat = 1; ready_pct = 70; rsp_pct = 80;
        for (int i = 0; i < 1500; i++) begin
            r1 = $urandom();
            r2 = $urandom();
            StallD = $urandom_range(99) < 25;
            br = ValidD && $urandom_range(99) < 4;
            jp = ValidD && $urandom_range(99) < 3;
            tick(br, {r1[31:2], 2'b00}, jp, {r2[27:2], 2'b00});
        end
        rnd_lat = 0; lat = 3; ready_pct = 100; rsp_pct = 100;
        StallD = 1;
        repeat (12) tick(0, '0, 0, '0);
        chk("full_reqv", 32'(last_reqv), 32'd0);
        chk("full_valid", 32'(last_valid), 32'd1);
        reset = 1;
        tick(0, '0, 0, '0);
        chk("rst_valid", 32'(ValidD), 32'd0);
        repeat (2) tick(0, '0, 0, '0);
        reset = 0;
        StallD = 0;
        tick(0, '0, 0, '0);
        chk("rst_reqv", 32'(last_reqv), 32'd1);
        chk("rst_addr", last_addr, RST_PC);
        wait_pc(RST_PC, "restart_pc");
        repeat (6) tick(0, '0, 0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
